// File: rtl/fetch_prefetch.sv
// fetch_prefetch: sequential instruction fetch into a PF_DEPTH-entry prefetch
// queue whose head is presented to decode.
//
// Memory handshake: mem_rd_enable is raised with mem_rd_addr and both are held
// stable until mem_rd_ready is seen high at a rising edge; mem_rd_ready is a
// one-cycle strobe and mem_rd_data is only valid in that cycle. Once issued, a
// request is never abandoned (except by reset). If a flush lands while a
// request is outstanding, the request still completes and its data is dropped.
// Decode handshake: the head is valid while pipeline_valid is high and is
// consumed at an edge where pipeline_valid=1 and stall=0.
module fetch_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                PF_DEPTH = 4,   // power of two, at least 2
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      mem_rd_enable,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic                      mem_rd_ready,
    input  logic [INSTR_W-1:0]        mem_rd_data,
    output logic [ADDR_W-1:0]         PC,
    output logic [INSTR_W-1:0]        instr,
    output logic                      pipeline_valid,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [ADDR_W-1:0]         flush_addr,
    output logic [$clog2(PF_DEPTH):0] fifo_count,
    output logic [1:0]                fsm_state
);

    localparam int PTR_W = $clog2(PF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   fetch_pc, fetch_pc_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [ADDR_W-1:0]   flush_target;
    logic [ADDR_W-1:0]   pc_plus;

    logic [ADDR_W-1:0]   q_pc    [PF_DEPTH];
    logic [INSTR_W-1:0]  q_instr [PF_DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count, count_nxt;
    logic                push, pop, has_room;

    // Redirect targets are word aligned; the low two bits are ignored.
    logic [1:0] unused_flush_lsbs;
    assign unused_flush_lsbs = flush_addr[1:0];
    assign flush_target      = {flush_addr[ADDR_W-1:2], 2'b00};
    assign pc_plus           = fetch_pc + ADDR_W'(PC_STEP);

    // Queue bookkeeping: push/pop decisions and the post-edge occupancy.
    always_comb begin
        push      = (state == ST_REQ) && mem_rd_ready && !flush;
        pop       = (count != '0) && !stall && !flush;
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
        has_room = (count_nxt < CNT_W'(PF_DEPTH));
    end

    // Fetch FSM: next state, next fetch PC, next request address, enable.
    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        addr_nxt      = mem_rd_addr;
        mem_rd_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush) begin
                    fetch_pc_nxt = flush_target;
                    addr_nxt     = flush_target;
                    state_nxt    = ST_REQ;
                end else if (has_room) begin
                    addr_nxt  = fetch_pc;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_rd_enable = 1'b1;
                if (flush) begin
                    fetch_pc_nxt = flush_target;
                    if (mem_rd_ready) begin
                        addr_nxt  = flush_target;
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = ST_DROP;
                    end
                end else if (mem_rd_ready) begin
                    fetch_pc_nxt = pc_plus;
                    if (has_room) begin
                        addr_nxt  = pc_plus;
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                // Stale request still in flight: keep its address until it
                // completes, then restart at the (possibly updated) fetch PC.
                mem_rd_enable = 1'b1;
                if (flush) begin
                    fetch_pc_nxt = flush_target;
                end
                if (mem_rd_ready) begin
                    addr_nxt  = fetch_pc_nxt;
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, fetch PC and request address registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            mem_rd_addr <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            mem_rd_addr <= addr_nxt;
        end
    end

    // Queue pointers and occupancy; a flush empties the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
        end
    end

    // Queue storage: {address, instruction} written on each accepted response.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= mem_rd_addr;
            q_instr[wr_ptr] <= mem_rd_data;
        end
    end

    // Head outputs are forced to zero while the queue is empty, which also
    // makes them read zero immediately under asynchronous reset.
    always_comb begin
        pipeline_valid = (count != '0);
        PC             = pipeline_valid ? q_pc[rd_ptr]    : '0;
        instr          = pipeline_valid ? q_instr[rd_ptr] : '0;
        fifo_count     = count;
        fsm_state      = state;
    end

endmodule
